// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with run-time CPOL/CPHA, bit order and slave select.
// Transfer framing: IDLE -> SETUP (CLK_DIV) -> XFER (2*DATA_W half-periods) -> HOLD (CLK_DIV).
module spi_master_cfg #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_SS  = 1,
  localparam int unsigned SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  logic                tick;
  logic                leading;
  logic                tx_bit;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   rx_shift;

  // Out-of-range selects decode to all-inactive.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
    ss_decode = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (32'(sel) == i) ss_decode[i] = 1'b0;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    sel_d     = sel_q;

    tick     = (div_q == DIV_LAST);
    leading  = ~edge_q[0];
    tx_bit   = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
    tx_shift = lsb_q ? {1'b0, tx_sr_q[DATA_W-1:1]} : {tx_sr_q[DATA_W-2:0], 1'b0};
    rx_shift = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        ss_n_d = '1;
        if (start) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          div_d   = '0;
          edge_d  = '0;
          rx_sr_d = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          sel_d   = ss_sel;
          ss_n_d  = ss_decode(ss_sel);
          // CPHA=0 presents the first bit before the leading edge.
          if (!cpha) begin
            mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
            tx_sr_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
          end else begin
            tx_sr_d = tx_data;
          end
        end
      end
      ST_SETUP: begin
        sclk_d = cpol_q;
        ss_n_d = ss_decode(sel_q);
        div_d  = div_q + DIV_W'(1);
        if (tick) begin
          div_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        div_d = div_q + DIV_W'(1);
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (leading ^ cpha_q) rx_sr_d = rx_shift;
          if (cpha_q ? leading : (!leading && edge_q != EDGE_LAST)) begin
            mosi_d  = tx_bit;
            tx_sr_d = tx_shift;
          end
          if (edge_q == EDGE_LAST) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        sclk_d = cpol_q;
        div_d  = div_q + DIV_W'(1);
        if (tick) begin
          div_d     = '0;
          edge_d    = '0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          ss_n_d    = '1;
          sclk_d    = cpol;
          rx_data_d = rx_sr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: behavioural SPI slave observes the bus, returns a slave word and
// records the word seen on mosi; each test task compares against values it derives itself.
module tb_spi_master_cfg;

  localparam int unsigned N = 8;
  localparam int unsigned D = 2;
  localparam int unsigned XFER_CYC = D * (2 * N + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [1:0] ss_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic       busy, done, sclk, mosi;
  logic       miso = 1'b0;
  logic [7:0] rx_data;
  logic [2:0] ss_n;

  int total = 0;
  int bad = 0;

  spi_master_cfg #(.DATA_W(N), .CLK_DIV(D), .NUM_SS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  // Slave model state, configured by the tests for the current transfer
  logic [7:0] slv_word = 8'h3C;
  logic       s_cpha = 1'b0;
  logic       s_lsb = 1'b0;
  logic [2:0] exp_ss = 3'b111;
  logic       mon_en = 1'b0;
  logic [7:0] cap = '0;
  int cnt = 0, last_edges = 0, busy_cycles = 0, done_cnt = 0, ss_err = 0;
  int run = 0, last_gap = 0, pos = 0, idx = 0;
  logic prev_busy = 1'b0, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy && sclk !== prev_sclk) begin
      cnt = cnt + 1;
      if (((cnt % 2) == 1) != (s_cpha == 1'b1)) begin
        pos = (cnt - 1) / 2;
        if (pos < 8) cap[s_lsb ? pos : 7 - pos] = mosi;
      end
    end
    if (prev_busy && busy !== 1'b1) last_edges = cnt;
    if (busy !== 1'b1) cnt = 0;
    idx = s_cpha ? ((cnt == 0) ? 0 : (cnt - 1) / 2) : cnt / 2;
    if (idx > 7) idx = 7;
    miso = slv_word[s_lsb ? idx : 7 - idx];
    if (busy === 1'b1) busy_cycles = busy_cycles + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (mon_en && rst_n && ss_n !== ((busy === 1'b1) ? exp_ss : 3'b111)) ss_err = ss_err + 1;
    if (ss_n[0] === 1'b1) run = run + 1;
    else begin
      if (run > 0) last_gap = run;
      run = 0;
    end
    prev_busy = (busy === 1'b1);
    prev_sclk = sclk;
  end

  task automatic start_xfer(input logic [7:0] tx, input logic [1:0] sel,
                            input logic pol, input logic pha, input logic lsb);
    @(negedge clk);
    tx_data = tx; ss_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb; start = 1'b1;
    s_cpha = pha; s_lsb = lsb;
    exp_ss = (sel < 2'd3) ? ~(3'b001 << sel) : 3'b111;
    busy_cycles = 0; done_cnt = 0; ss_err = 0; cap = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    total++; if (ss_n !== 3'b111) begin bad++; $display("FAIL reset_ss_n got=%b exp=111", ss_n); end
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    bit seen;
    slv_word = 8'h3C;
    start_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL m0_timeout got=no_done exp=done"); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL m0_rx got=%h exp=3c", rx_data); end
    repeat (4) @(negedge clk);
    total++; if (cap !== 8'hA5) begin bad++; $display("FAIL m0_mosi got=%h exp=a5", cap); end
    total++; if (busy_cycles != XFER_CYC) begin bad++; $display("FAIL m0_busy_len got=%0d exp=%0d", busy_cycles, XFER_CYC); end
    total++; if (last_edges != 2 * N) begin bad++; $display("FAIL m0_edges got=%0d exp=%0d", last_edges, 2 * N); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL m0_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (ss_err != 0) begin bad++; $display("FAIL m0_ss_n got=%0d_errs exp=0", ss_err); end
  endtask

  task automatic test_mode3();
    bit seen;
    @(negedge clk);
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_idle_sclk got=%b exp=1", sclk); end
    start_xfer(8'h81, 2'd0, 1'b1, 1'b1, 1'b1);
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL m3_timeout got=no_done exp=done"); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL m3_rx got=%h exp=3c", rx_data); end
    repeat (2) @(negedge clk);
    total++; if (cap !== 8'h81) begin bad++; $display("FAIL m3_mosi got=%h exp=81", cap); end
    total++; if (last_edges != 2 * N) begin bad++; $display("FAIL m3_edges got=%0d exp=%0d", last_edges, 2 * N); end
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_end_sclk got=%b exp=1", sclk); end
    cpol = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    bit seen;
    start_xfer(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF; ss_sel = 2'd1; cpha = 1'b1; lsb_first = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL ign_timeout got=no_done exp=done"); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL ign_rx got=%h exp=3c", rx_data); end
    repeat (6) @(negedge clk);
    total++; if (cap !== 8'h5A) begin bad++; $display("FAIL ign_mosi got=%h exp=5a", cap); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (ss_err != 0) begin bad++; $display("FAIL ign_ss_n got=%0d_errs exp=0", ss_err); end
    cpha = 1'b0; lsb_first = 1'b0; ss_sel = 2'd0;
  endtask

  task automatic test_ss_sel();
    bit seen;
    for (int s = 2; s <= 3; s++) begin
      start_xfer(8'h3C ^ 8'(s), 2'(s), 1'b0, 1'b0, 1'b0);
      wait_done(seen);
      total++; if (!seen) begin bad++; $display("FAIL sel%0d_timeout got=no_done exp=done", s); end
      total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL sel%0d_rx got=%h exp=3c", s, rx_data); end
      @(negedge clk);
      total++; if (busy_cycles != XFER_CYC) begin bad++; $display("FAIL sel%0d_busy_len got=%0d exp=%0d", s, busy_cycles, XFER_CYC); end
      total++; if (ss_err != 0) begin bad++; $display("FAIL sel%0d_ss_n got=%0d_errs exp=0", s, ss_err); end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    bit reached;
    logic [7:0] tx;
    start_xfer(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cnt >= 8) begin reached = 1'b1; break; end
    end
    total++; if (!reached) begin bad++; $display("FAIL abort_reach got=%0d_edges exp=8", cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (ss_n !== 3'b111) begin bad++; $display("FAIL abort_ss_n got=%b exp=111", ss_n); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk got=%b exp=0", sclk); end
    repeat (40) @(negedge clk);
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    tx = 8'($urandom);
    slv_word = 8'($urandom);
    start_xfer(tx, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_done(seen);
    total++; if (rx_data !== slv_word) begin bad++; $display("FAIL abort_next_rx got=%h exp=%h", rx_data, slv_word); end
    @(negedge clk);
    total++; if (cap !== tx) begin bad++; $display("FAIL abort_next_mosi got=%h exp=%h", cap, tx); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [7:0] t1, t2, w1, w2;
    t1 = 8'($urandom); t2 = ~t1; w1 = 8'($urandom); w2 = w1 ^ 8'h5A;
    slv_word = w1;
    @(negedge clk);
    tx_data = t1; ss_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; start = 1'b1;
    s_cpha = 1'b0; s_lsb = 1'b0; exp_ss = 3'b110; ss_err = 0; cap = '0; done_cnt = 0;
    @(negedge clk);
    tx_data = t2;
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL b2b_timeout1 got=no_done exp=done"); end
    total++; if (rx_data !== w1) begin bad++; $display("FAIL b2b_rx1 got=%h exp=%h", rx_data, w1); end
    total++; if (cap !== t1) begin bad++; $display("FAIL b2b_mosi1 got=%h exp=%h", cap, t1); end
    slv_word = w2;
    busy_cycles = 0;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    total++; if (!seen) begin bad++; $display("FAIL b2b_timeout2 got=no_done exp=done"); end
    total++; if (rx_data !== w2) begin bad++; $display("FAIL b2b_rx2 got=%h exp=%h", rx_data, w2); end
    @(negedge clk);
    total++; if (cap !== t2) begin bad++; $display("FAIL b2b_mosi2 got=%h exp=%h", cap, t2); end
    total++; if (last_gap != 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=1", last_gap); end
    total++; if (busy_cycles != XFER_CYC) begin bad++; $display("FAIL b2b_busy_len got=%0d exp=%0d", busy_cycles, XFER_CYC); end
    repeat (3) @(negedge clk);
    total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_random();
    bit seen;
    logic [7:0] tx;
    logic pol, pha, lsb;
    logic [1:0] sel;
    for (int k = 0; k < 8; k++) begin
      tx = 8'($urandom); slv_word = 8'($urandom);
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
      sel = 2'($urandom_range(0, 3));
      @(negedge clk);
      cpol = pol;
      repeat (2) @(negedge clk);
      start_xfer(tx, sel, pol, pha, lsb);
      wait_done(seen);
      total++; if (rx_data !== slv_word) begin bad++; $display("FAIL rnd%0d_rx got=%h exp=%h", k, rx_data, slv_word); end
      @(negedge clk);
      total++; if (cap !== tx) begin bad++; $display("FAIL rnd%0d_mosi got=%h exp=%h", k, cap, tx); end
      total++; if (busy_cycles != XFER_CYC) begin bad++; $display("FAIL rnd%0d_busy_len got=%0d exp=%0d", k, busy_cycles, XFER_CYC); end
      total++; if (ss_err != 0) begin bad++; $display("FAIL rnd%0d_ss_n got=%0d_errs exp=0", k, ss_err); end
      total++; if (sclk !== pol) begin bad++; $display("FAIL rnd%0d_idle_sclk got=%b exp=%b", k, sclk, pol); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_ignore_start();
    test_ss_sel();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
